// File: rtl/bus_rx_terminal.sv
// Receive-side bus terminal: filters pushed packets by destination ID and
// buffers accepted ones in a first-word-fall-through FIFO for the local consumer.
module bus_rx_terminal #(
  parameter int unsigned pckg_sz   = 16,
  parameter int unsigned fif_Size  = 10,
  parameter int unsigned drvrs     = 4,
  parameter int unsigned id        = 0,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [pckg_sz-1:0]            D_push,
  input  logic                          pop,
  output logic [pckg_sz-1:0]            D_pop,
  output logic                          pndng,
  output logic                          full,
  output logic [$clog2(fif_Size+1)-1:0] count,
  output logic [7:0]                    drop_cnt
);

  localparam int unsigned PTR_W  = (fif_Size > 1) ? $clog2(fif_Size) : 1;
  localparam int unsigned CNT_W  = $clog2(fif_Size + 1);
  localparam logic [7:0]  ID_HDR = 8'(id);

  if (id >= drvrs || id == broadcast) begin : g_bad_id
    $fatal(1, "bus_rx_terminal: id must be < drvrs and differ from broadcast");
  end

  logic [pckg_sz-1:0] mem [fif_Size];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic [7:0]         drop_q,   drop_d;

  logic [7:0] hdr;
  logic       match, wr_en, rd_en, drop_en;

  // Depth need not be a power of two, so wrap on an explicit compare.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(fif_Size - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pndng = (count_q != '0);
  assign full  = (count_q == CNT_W'(fif_Size));

  always_comb begin
    hdr     = D_push[pckg_sz-1 -: 8];
    match   = push && (hdr == ID_HDR || hdr == broadcast);
    rd_en   = pop && pndng;
    // A pop while full frees the head slot in the same edge, so the push still lands.
    wr_en   = match && (!full || rd_en);
    drop_en = match && full && !pop;

    wr_ptr_d = wr_en ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_en ? next_ptr(rd_ptr_q) : rd_ptr_q;

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    drop_d = (drop_en && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // NOTE: packet storage is deliberately not reset; count gates visibility,
  // and leaving it reset-free lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= D_push;
  end

  assign D_pop    = pndng ? mem[rd_ptr_q] : '0;
  assign count    = count_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_bus_rx_terminal.sv
// Scoreboard bench for bus_rx_terminal (id=2): directed cases plus random traffic
// checked against a queue-based reference model.
module tb_bus_rx_terminal;

  localparam int DEPTH = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        push = 1'b0;
  logic [15:0] D_push = '0;
  logic        pop = 1'b0;
  logic [15:0] D_pop;
  logic        pndng, full;
  logic [3:0]  count;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int failures = 0;

  logic [15:0] ref_q[$];   // reference FIFO contents
  logic [15:0] sb_q[$];    // expected pop order, consumed by the monitor
  int          m_drop = 0;

  bus_rx_terminal #(.pckg_sz(16), .fif_Size(DEPTH), .drvrs(4), .id(2), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .push(push), .D_push(D_push), .pop(pop),
    .D_pop(D_pop), .pndng(pndng), .full(full), .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour for one clock, applied to the model before the edge.
  task automatic model_step(input logic rst, input logic ps, input logic [15:0] d, input logic pp);
    bit m, rd, was_full;
    if (rst) begin
      ref_q.delete();
      sb_q.delete();
      m_drop = 0;
      return;
    end
    m        = ps && (d[15:8] == 8'h02 || d[15:8] == 8'hFF);
    rd       = pp && ref_q.size() > 0;
    was_full = ref_q.size() == DEPTH;
    if (rd) void'(ref_q.pop_front());
    if (m) begin
      if (!was_full || rd) begin
        ref_q.push_back(d);
        sb_q.push_back(d);
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end
  endtask

  task automatic check_state();
    int n = ref_q.size();
    check("count", 32'(count), 32'(n));
    check("full", 32'(full), 32'(n == DEPTH));
    check("pndng", 32'(pndng), 32'(n != 0));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check("d_pop_head", 32'(D_pop), (n != 0) ? 32'(ref_q[0]) : 32'd0);
  endtask

  task automatic cycle(input logic rst, input logic ps, input logic [15:0] d, input logic pp);
    @(negedge clk);
    reset = rst; push = ps; D_push = d; pop = pp;
    model_step(rst, ps, d, pp);
    @(posedge clk);
    #1;
    check_state();
  endtask

  // Monitor: whenever the DUT is about to accept a pop, its head must be the
  // oldest expected packet.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset && pop && pndng) begin
        if (sb_q.size() == 0) check("pop_underflow", 32'(D_pop), 32'hDEAD_BEEF);
        else                  check("pop_data", 32'(D_pop), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] rand_pkt();
    logic [7:0] h;
    case ($urandom_range(0, 3))
      0:       h = 8'h02;
      1:       h = 8'hFF;
      2:       h = ($urandom_range(0, 1) == 0) ? 8'h03 : 8'h00;
      default: h = 8'($urandom);
    endcase
    return {h, 8'($urandom)};
  endfunction

  initial begin
    // 1: reset held with push and pop active
    for (int i = 0; i < 3; i++) cycle(1, 1, 16'h02AB, 1);
    check("rst_count", 32'(count), 0);
    check("rst_dpop", 32'(D_pop), 0);

    // 2: destination filter
    cycle(0, 1, 16'h02AB, 0);
    cycle(0, 1, 16'h03CD, 0);
    cycle(0, 1, 16'hFF11, 0);
    check("filter_count", 32'(count), 2);
    cycle(0, 0, 16'h0000, 1);
    cycle(0, 0, 16'h0000, 1);
    check("filter_empty", 32'(pndng), 0);

    // 3: overflow by one packet
    for (int i = 0; i < 11; i++) cycle(0, 1, 16'h0200 + 16'(i), 0);
    check("ovf_full", 32'(full), 1);
    check("ovf_drop", 32'(drop_cnt), 1);

    // 4: push+pop while full
    cycle(0, 1, 16'h02EE, 1);
    check("fullpp_count", 32'(count), DEPTH);
    check("fullpp_drop", 32'(drop_cnt), 1);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 16'h0000, 1);

    // 5: empty edge cases
    cycle(0, 0, 16'h0000, 1);
    cycle(0, 1, 16'h0201, 1);
    check("emptypp_count", 32'(count), 1);
    check("emptypp_dpop", 32'(D_pop), 16'h0201);
    cycle(0, 0, 16'h0000, 1);

    // Drop counter saturation
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 16'hFF00 + 16'(i), 0);
    for (int i = 0; i < 260; i++) cycle(0, 1, 16'h0277, 0);
    check("drop_sat", 32'(drop_cnt), 8'hFF);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 16'h0000, 1);

    // Random traffic in fill-biased and drain-biased phases
    for (int ph = 0; ph < 6; ph++) begin
      int pop_pct = (ph % 2 == 0) ? 25 : 80;
      for (int i = 0; i < 150; i++)
        cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 70), rand_pkt(),
              ($urandom_range(0, 99) < pop_pct));
    end

    // 6: interleaved traffic across pointer wrap, then reset at count=5
    cycle(1, 0, 16'h0000, 0);
    for (int i = 0; i < 25; i++) cycle(0, 1, 16'h0200 + 16'(i), (i % 3) != 0);
    while (ref_q.size() > 5) cycle(0, 0, 16'h0000, 1);
    while (ref_q.size() < 5) cycle(0, 1, 16'h0250, 0);
    check("pre_rst_count", 32'(count), 5);
    cycle(1, 0, 16'h0000, 0);
    check("post_rst_count", 32'(count), 0);
    check("post_rst_pndng", 32'(pndng), 0);
    check("post_rst_drop", 32'(drop_cnt), 0);
    cycle(0, 0, 16'h0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
